// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant, 3-state FSM; ALU_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
// Latency: accept in cycle N, response valid in cycle N+2. A stalled rsp_ready holds the response and blocks every requester.
module alu_share_arb #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 64,
  parameter int ALU_SEL_W = 6,
  parameter int ID_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ALU_SEL_W-1:0] req_ctl,
  input  logic [NREQ*DATA_W-1:0]    req_a,
  input  logic [NREQ*DATA_W-1:0]    req_b,
  output logic [ALU_SEL_W-1:0]      alu_ctl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       op_id;
  logic [ALU_SEL_W-1:0]  op_ctl;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  rsp_zero_q;
  logic                  rsp_valid_q;
  logic                  busy_q;

  logic                  win_vld;
  logic [ID_W-1:0]       win_id;
  logic [ALU_SEL_W-1:0]  win_ctl;
  logic [DATA_W-1:0]     win_a;
  logic [DATA_W-1:0]     win_b;
  logic [ID_W-1:0]       next_ptr;
  int                    idx;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_ctl = '0;
    win_a   = '0;
    win_b   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (!win_vld && idx != 0 && req_valid[idx]) begin
`else
      if (!win_vld && req_valid[idx]) begin
`endif
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
        win_ctl = req_ctl[idx*ALU_SEL_W +: ALU_SEL_W];
        win_a   = req_a[idx*DATA_W +: DATA_W];
        win_b   = req_b[idx*DATA_W +: DATA_W];
      end
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (req_valid[0]) begin
      win_vld = 1'b1;
      win_id  = '0;
      win_ctl = req_ctl[ALU_SEL_W-1:0];
      win_a   = req_a[DATA_W-1:0];
      win_b   = req_b[DATA_W-1:0];
    end
`endif
  end

  // Pointer moves just past the requester that was served.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (op_id == '0)
      next_ptr = rr_ptr;
    else if (op_id == ID_W'(NREQ-1))
      next_ptr = ID_W'(1);
    else
      next_ptr = op_id + ID_W'(1);
`else
    if (op_id == ID_W'(NREQ-1))
      next_ptr = '0;
    else
      next_ptr = op_id + ID_W'(1);
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_vld)
      req_ready = NREQ'(1) << win_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op_id       <= '0;
      op_ctl      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            op_id  <= win_id;
            op_ctl <= win_ctl;
            op_a   <= win_a;
            op_b   <= win_b;
            state  <= EXEC;
            busy_q <= 1'b1;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_zero_q  <= alu_zero;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign alu_ctl   = op_ctl;
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = op_id;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural shared ALU; covers both builds of ALU_ARB_FIXED_PRIO_EN.
module tb_alu_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int SW   = 6;
  localparam int IW   = 2;

  localparam logic [SW-1:0] ALU_AND = 6'd0;
  localparam logic [SW-1:0] ALU_OR  = 6'd1;
  localparam logic [SW-1:0] ALU_ADD = 6'd2;
  localparam logic [SW-1:0] ALU_XOR = 6'd3;
  localparam logic [SW-1:0] ALU_SUB = 6'd6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*SW-1:0] req_ctl;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [SW-1:0]      alu_ctl;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic [DW-1:0]      alu_out;
  logic               alu_zero;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_zero;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arb #(.NREQ(NREQ), .DATA_W(DW), .ALU_SEL_W(SW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unknown selects return 0.
  always_comb begin
    case (alu_ctl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [SW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_ctl[i*SW +: SW] = c;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
  endtask

  // One full transaction with rsp_ready high: grant, EXEC, RESP, back to IDLE.
  task automatic op(input string tag, input logic [NREQ-1:0] vld, input logic [NREQ-1:0] exp_rdy,
                    input logic [SW-1:0] exp_ctl, input logic [DW-1:0] exp_a,
                    input logic [DW-1:0] exp_data, input logic exp_zero, input int exp_id);
    req_valid = vld;
    #1;
    chk({tag, ".grant"}, DW'(req_ready), DW'(exp_rdy));
    step;
    chk({tag, ".exec_busy"}, DW'(busy), 64'd1);
    chk({tag, ".exec_rdy"}, DW'(req_ready), 64'd0);
    chk({tag, ".exec_ctl"}, DW'(alu_ctl), DW'(exp_ctl));
    chk({tag, ".exec_a"}, alu_a, exp_a);
    chk({tag, ".exec_vld"}, DW'(rsp_valid), 64'd0);
    step;
    chk({tag, ".rsp_vld"}, DW'(rsp_valid), 64'd1);
    chk({tag, ".rsp_id"}, DW'(rsp_id), DW'(exp_id));
    chk({tag, ".rsp_data"}, rsp_data, exp_data);
    chk({tag, ".rsp_zero"}, DW'(rsp_zero), DW'(exp_zero));
    chk({tag, ".rsp_rdy"}, DW'(req_ready), 64'd0);
    step;
    chk({tag, ".done_vld"}, DW'(rsp_valid), 64'd0);
    chk({tag, ".done_busy"}, DW'(busy), 64'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".ready"}, DW'(req_ready), 64'd0);
    chk({tag, ".alu_ctl"}, DW'(alu_ctl), 64'd0);
    chk({tag, ".alu_a"}, alu_a, 64'd0);
    chk({tag, ".alu_b"}, alu_b, 64'd0);
    chk({tag, ".rsp_vld"}, DW'(rsp_valid), 64'd0);
    chk({tag, ".rsp_id"}, DW'(rsp_id), 64'd0);
    chk({tag, ".rsp_data"}, rsp_data, 64'd0);
    chk({tag, ".rsp_zero"}, DW'(rsp_zero), 64'd0);
    chk({tag, ".busy"}, DW'(busy), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_ctl   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;
    step;

`ifdef ALU_ARB_FIXED_PRIO_EN
    set_slot(0, ALU_ADD, 64'd1, 64'd1);
    set_slot(1, ALU_ADD, 64'd10, 64'd20);
    set_slot(3, ALU_ADD, 64'd3, 64'd4);
    for (int n = 0; n < 3; n++)
      op("prio0", 4'b0011, 4'b0001, ALU_ADD, 64'd1, 64'd2, 1'b0, 0);
    op("drop0", 4'b0010, 4'b0010, ALU_ADD, 64'd10, 64'd30, 1'b0, 1);
    op("rr13", 4'b1010, 4'b1000, ALU_ADD, 64'd3, 64'd7, 1'b0, 3);
    op("prio0b", 4'b1011, 4'b0001, ALU_ADD, 64'd1, 64'd2, 1'b0, 0);
`else
    set_slot(2, ALU_ADD, 64'd5, 64'd7);
    op("single", 4'b0100, 4'b0100, ALU_ADD, 64'd5, 64'd12, 1'b0, 2);

    set_slot(3, ALU_XOR, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    op("xor", 4'b1111, 4'b1000, ALU_XOR, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 3);

    set_slot(0, ALU_SUB, 64'd9, 64'd9);
    op("wrap", 4'b0101, 4'b0001, ALU_SUB, 64'd9, 64'd0, 1'b1, 0);

    // Reset while the op is in EXEC: nothing may survive.
    set_slot(1, ALU_ADD, 64'd1, 64'd2);
    req_valid = 4'b0010;
    step;
    req_valid = '0;
    chk("midrst.exec_busy", DW'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrst");
    step;
    rst_n = 1'b1;
    step;
    chk("midrst.no_rsp1", DW'(rsp_valid), 64'd0);
    step;
    chk("midrst.no_rsp2", DW'(rsp_valid), 64'd0);

    for (int i = 0; i < NREQ; i++) set_slot(i, ALU_SUB, 64'd9, 64'd9);
    for (int n = 0; n < 5; n++)
      op("fair", 4'b1111, 4'(1 << (n % 4)), ALU_SUB, 64'd9, 64'd0, 1'b1, n % 4);

    set_slot(1, ALU_AND, 64'hF0, 64'h3C);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("bp.grant", DW'(req_ready), 64'b0010);
    step;
    step;
    for (int n = 0; n < 10; n++) begin
      chk("bp.vld", DW'(rsp_valid), 64'd1);
      chk("bp.data", rsp_data, 64'h30);
      chk("bp.id", DW'(rsp_id), 64'd1);
      chk("bp.rdy", DW'(req_ready), 64'd0);
      chk("bp.busy", DW'(busy), 64'd1);
      step;
    end
    rsp_ready = 1'b1;
    step;
    chk("bp.done_vld", DW'(rsp_valid), 64'd0);
    chk("bp.next_grant", DW'(req_ready), 64'b0100);

    set_slot(2, 6'd45, 64'd123, 64'd4);
    op("unk_sel", 4'b0100, 4'b0100, 6'd45, 64'd123, 64'd0, 1'b1, 2);
`endif

    req_valid = '0;
    step;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
